// File: rtl/mod_mem_monitor.sv
// Memory-modification monitor: flags CPU writes and DMA burst beats that
// land in the attested region (AR) or the LMT reserved window. Flags are
// registered one-cycle pulses; AR hits are also counted (saturating).
module mod_mem_monitor #(
   parameter logic [31:0] AR_MIN  = 32'h0000_2000,
   parameter logic [31:0] AR_MAX  = 32'h0000_3FFF,
   parameter logic [31:0] LMT_MIN = 32'h0000_0FF0,
   parameter logic [31:0] LMT_MAX = 32'h0000_0FFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_wen,
   input  logic [31:0] cpu_waddr,
   input  logic        dma_start,
   input  logic [31:0] dma_addr,
   input  logic [7:0]  dma_len,
   input  logic        dma_beat,
   output logic        dma_busy,
   output logic        Mod_Mem_AR,
   output logic        Mod_Mem_LMT,
   output logic [15:0] ar_mod_count
);

   typedef enum logic {IDLE, BURST} state_t;

   state_t      state_q, state_d;
   logic [31:0] baddr_q, baddr_d;
   logic [7:0]  bcnt_q,  bcnt_d;
   logic        ar_q,    ar_d;
   logic        lmt_q,   lmt_d;
   logic [15:0] arcnt_q, arcnt_d;
   logic        dma_chk;

   // Inclusive unsigned range test. Written as an offset compare so a
   // range starting at 0 needs no always-true "a >= 0" term; assumes lo <= hi.
   function automatic logic in_rng(input logic [31:0] a,
                                   input logic [31:0] lo,
                                   input logic [31:0] hi);
      return (a - lo) <= (hi - lo);
   endfunction

   // Burst FSM: load address/length on a non-empty start, step per beat
   always_comb begin
      state_d = state_q;
      baddr_d = baddr_q;
      bcnt_d  = bcnt_q;
      dma_chk = 1'b0;
      case (state_q)
         IDLE: begin
            if (dma_start && (dma_len != 8'd0)) begin
               state_d = BURST;
               baddr_d = dma_addr;
               bcnt_d  = dma_len;
            end
         end
         BURST: begin
            if (dma_beat) begin
               dma_chk = 1'b1;
               baddr_d = baddr_q + 32'd4;   // wraps modulo 2^32
               bcnt_d  = bcnt_q - 8'd1;
               if (bcnt_q == 8'd1) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Hit detection: CPU and DMA hits in one cycle merge into one pulse
   always_comb begin
      ar_d  = (cpu_wen && in_rng(cpu_waddr, AR_MIN, AR_MAX)) ||
              (dma_chk && in_rng(baddr_q, AR_MIN, AR_MAX));
      lmt_d = (cpu_wen && in_rng(cpu_waddr, LMT_MIN, LMT_MAX)) ||
              (dma_chk && in_rng(baddr_q, LMT_MIN, LMT_MAX));
      arcnt_d = arcnt_q;
      if (ar_d && (arcnt_q != 16'hFFFF)) arcnt_d = arcnt_q + 16'd1;
   end

   // State and flag registers; reset also abandons any burst in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         baddr_q <= 32'd0;
         bcnt_q  <= 8'd0;
         ar_q    <= 1'b0;
         lmt_q   <= 1'b0;
         arcnt_q <= 16'd0;
      end else begin
         state_q <= state_d;
         baddr_q <= baddr_d;
         bcnt_q  <= bcnt_d;
         ar_q    <= ar_d;
         lmt_q   <= lmt_d;
         arcnt_q <= arcnt_d;
      end
   end

   assign dma_busy     = (state_q == BURST);
   assign Mod_Mem_AR   = ar_q;
   assign Mod_Mem_LMT  = lmt_q;
   assign ar_mod_count = arcnt_q;

endmodule

// File: doc/mod_mem_monitor.md
MOD_MEM_MONITOR -- requirements
Module: mod_mem_monitor

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  AR_MIN  32'h0000_2000  inclusive lower byte address of the attested region (AR)
  AR_MAX  32'h0000_3FFF  inclusive upper byte address of AR
  LMT_MIN  32'h0000_0FF0  inclusive lower byte address of the LMT reserved memory
  LMT_MAX  32'h0000_0FFF  inclusive upper byte address of LMT
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single clock; all state updates on rising edge
  rst_n  in  1  asynchronous, active-low reset
  cpu_wen  in  1  CPU write strobe, one write per cycle high
  cpu_waddr  in  32  CPU write byte address
  dma_start  in  1  DMA burst request, sampled in IDLE only
  dma_addr  in  32  burst start byte address, sampled with dma_start
  dma_len  in  8  burst length in 32-bit beats, sampled with dma_start
  dma_beat  in  1  one DMA word written this cycle
  dma_busy  out  1  high while in BURST
  Mod_Mem_AR  out  1  one-cycle pulse per write that hit AR; drives the attestation monitor
  Mod_Mem_LMT  out  1  one-cycle pulse per write that hit LMT; drives the attestation monitor
  ar_mod_count  out  16  saturating count of AR-hit cycles since reset
REQ-003 Reset SHALL be asynchronous, active-low, on rst_n; the single clock SHALL be clk.

Function
REQ-004 An address SHALL hit AR iff AR_MIN <= addr <= AR_MAX, and LMT iff LMT_MIN <= addr <= LMT_MAX, unsigned 32-bit compares.
REQ-005 Overlapping ranges SHALL NOT be an error; an address in both ranges SHALL flag both outputs.
REQ-006 FSM SHALL have two states: IDLE and BURST.
REQ-007 IDLE -> BURST SHALL occur on dma_start=1 with dma_len != 0; dma_addr SHALL load into the beat address register and dma_len into the remaining-beat counter.
REQ-008 dma_start with dma_len=0 SHALL be ignored: state stays IDLE, no flags.
REQ-009 dma_start while in BURST SHALL be ignored; the current burst SHALL continue unchanged.
REQ-010 In BURST, each cycle with dma_beat=1 SHALL check the beat address register, then add 4 to it and decrement the counter by 1.
REQ-011 BURST -> IDLE SHALL occur on the edge at which the counter decrements from 1 to 0; dma_busy SHALL be low from the following cycle.
REQ-012 dma_beat while in IDLE SHALL be ignored.
REQ-013 Beat address SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0000_0000); checking SHALL continue after the wrap.
REQ-014 cpu_wen SHALL be checked every cycle, in either state, using cpu_waddr.
REQ-015 A cycle with a CPU hit and a DMA hit in the same cycle SHALL produce one pulse per output (ORed), not two.
REQ-016 Mod_Mem_AR and Mod_Mem_LMT SHALL be registered: a hit sampled at edge N SHALL appear high for exactly the cycle after edge N and be low at edge N+1 unless hit again.
REQ-017 Back-to-back hits on consecutive edges SHALL hold the output high continuously.
REQ-018 ar_mod_count SHALL increment by 1 on each edge where Mod_Mem_AR is being set, and saturate at 16'hFFFF.
REQ-019 No combinational path SHALL exist from any input to any output.

Reset
REQ-020 rst_n=0 SHALL immediately force: state IDLE, dma_busy=0, Mod_Mem_AR=0, Mod_Mem_LMT=0, ar_mod_count=0, beat address=0, beat counter=0.
REQ-021 Reset asserted mid-burst SHALL abandon the burst; after release, no flags SHALL be produced for remaining beats until a new dma_start.
REQ-022 The first edge after rst_n rises SHALL be fully functional, with no dead cycle.

Verification
REQ-023 CPU write 32'h0000_2000, then 32'h0000_3FFF, then 32'h0000_4000 on consecutive cycles -> Mod_Mem_AR high two cycles then low; ar_mod_count=2; Mod_Mem_LMT stays 0.
REQ-024 CPU write 32'h0000_0FEC, then 32'h0000_0FF0 -> no pulse, then a single Mod_Mem_LMT pulse one cycle after the second write.
REQ-025 dma_start with addr 32'h0000_1FF8, len 4, and 4 beats -> beats at 1FF8 and 1FFC give no flag; beats at 2000 and 2004 give AR pulses; dma_busy falls after the 4th beat; count=2.
REQ-026 dma_start with addr 32'hFFFF_FFF8, len 3, 3 beats; LMT_MIN lowered to 0 in a bench parameter override -> third beat at 32'h0000_0000 flags Mod_Mem_LMT.
REQ-027 CPU write 32'h0000_2100 in the same cycle as a DMA beat at 32'h0000_2200 -> one Mod_Mem_AR pulse; ar_mod_count +1.
REQ-028 rst_n pulsed low after beat 2 of a len-8 burst into AR -> outputs 0 at once; further dma_beat gives no flags; dma_busy=0; count=0.
